blink_monitor: RTL and testbench
================================

BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 Parameters SHALL be:
- CBITS, default 15, blinker counter width; expected half-period EXP_HALF = 2^CBITS cycles.
- TOL, default 2, allowed ± deviation of a measured half-period, in cycles.
- LOCK_N, default 4, consecutive good half-periods needed for lock (1..15).

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- led_in  in  1  blink signal under test, synchronous to clk.
- clr_err  in  1  clears err_sticky.
- edge_pulse  out  1  one-cycle pulse per measured led_in transition.
- half_period  out  CBITS+1  last measured interval between transitions, in cycles.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on loss of lock.
- err_sticky  out  1  latched fault flag.

Function
REQ-003 led_q SHALL register led_in each cycle; edge = (led_in != led_q).
REQ-004 Interval counter cnt (CBITS+1 bits) SHALL load 1 on edge, else increment, saturating at all-ones (no wrap).
REQ-005 On an edge, the measured interval SHALL be the pre-load value of cnt, i.e. cycles since the previous edge.
REQ-006 An interval SHALL be good iff EXP_HALF-TOL <= interval <= EXP_HALF+TOL, compared unsigned at CBITS+2 bits.
REQ-007 Timeout SHALL be cnt == EXP_HALF+TOL with no edge this cycle; it fires at most once per interval.
REQ-008 The FSM SHALL have states IDLE, SYNC, LOCKED, FAULT and a good-run counter good_cnt (4 bits).
REQ-009 In IDLE:
- edge -> SYNC, good_cnt=0.
- No interval is measured on this edge; half_period and edge_pulse are unchanged.
REQ-010 In SYNC:
- good edge -> good_cnt+1; on reaching LOCK_N -> LOCKED.
- bad edge -> good_cnt=0, stay in SYNC.
- timeout -> IDLE, good_cnt=0.
REQ-011 In LOCKED:
- good edge -> stay.
- bad edge or timeout -> FAULT, assert err_pulse and set err_sticky.
REQ-012 In FAULT: edge -> SYNC, good_cnt=0, no measurement check; timeout is ignored.
REQ-013 On any edge outside IDLE, half_period SHALL take the measured interval and edge_pulse SHALL be 1, both on the cycle after the edge.
REQ-014 locked, err_pulse and err_sticky SHALL be registered; each changes on the cycle after its causing edge or timeout.
REQ-015 clr_err SHALL clear err_sticky on the next cycle; if a new fault and clr_err coincide, set SHALL win.
REQ-016 With LOCK_N=1, the first good edge in SYNC SHALL lock.
REQ-017 A saturated cnt SHALL never compare good.

Reset
REQ-018 While rst=0, the block SHALL hold these values, and it SHALL resume on the first clk edge after rst rises:
- state=IDLE, led_q=0, cnt=0, good_cnt=0.
- half_period=0, edge_pulse=0, locked=0, err_pulse=0, err_sticky=0.
REQ-019 Reset asserted mid-measurement or while LOCKED SHALL abort immediately with no err_pulse.
REQ-020 led_in=1 at reset release SHALL count as the first edge (IDLE -> SYNC).

Verification (CBITS=4 so EXP_HALF=16, TOL=2, LOCK_N=4)
REQ-021 Toggle led_in every 16 cycles:
- 5th toggle (4th good interval) -> locked=1 the following cycle.
- half_period=16 on every edge_pulse.
- err_sticky stays 0.
REQ-022 Boundary intervals 14 and 18 -> counted good. Intervals 13 and 19 -> good_cnt reset, no lock.
REQ-023 While locked, hold led_in for 18 cycles with no edge:
- err_pulse high for exactly 1 cycle.
- err_sticky=1, locked=0, state FAULT.
- Next edge -> SYNC.
REQ-024 While locked, an edge after 10 cycles -> err_pulse, half_period=10, FAULT.
REQ-025 clr_err coinciding with a new fault -> err_sticky remains 1. clr_err alone -> err_sticky=0 the next cycle.
REQ-026 rst pulled low mid-interval while locked -> all outputs 0 asynchronously, no err_pulse. After release, 5 toggles at 16-cycle spacing relock.

Source files
------------

// File: rtl/blink_monitor.sv
// Blink monitor: times the half-periods of a blinking LED signal,
// locks onto a steady blink rate and flags a fault when lock is lost.
module blink_monitor #(
  parameter int CBITS  = 15,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           led_in,
  input  logic           clr_err,
  output logic           edge_pulse,
  output logic [CBITS:0] half_period,
  output logic           locked,
  output logic           err_pulse,
  output logic           err_sticky
);

  localparam int EXP_HALF = 1 << CBITS;

  localparam logic [CBITS+1:0] LO =
    (CBITS+2)'(EXP_HALF - TOL);
  localparam logic [CBITS+1:0] HI =
    (CBITS+2)'(EXP_HALF + TOL);
  localparam logic [CBITS:0] TO_VAL =
    (CBITS+1)'(EXP_HALF + TOL);
  localparam logic [CBITS:0] CNT_MAX = '1;
  localparam logic [CBITS:0] CNT_ONE =
    (CBITS+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_LOCKED,
    S_FAULT
  } state_e;

  state_e         state_q, state_d;
  logic           led_q, led_d;
  logic [CBITS:0] cnt_q, cnt_d;
  logic [3:0]     good_q, good_d;
  logic [CBITS:0] hp_q, hp_d;
  logic           ep_q, ep_d;
  logic           lk_q, lk_d;
  logic           err_q, err_d;
  logic           stk_q, stk_d;

  logic           edge_w;
  logic           good_w;
  logic           tout_w;
  logic           fault_w;
  logic [3:0]     gnext;

  always_comb begin
    led_d   = led_in;
    edge_w  = (led_in != led_q);
    good_w  = ({1'b0, cnt_q} >= LO) &&
              ({1'b0, cnt_q} <= HI);
    tout_w  = !edge_w && (cnt_q == TO_VAL);
    gnext   = good_q + 4'd1;
    fault_w = 1'b0;
    state_d = state_q;
    good_d  = good_q;

    if (edge_w)
      cnt_d = CNT_ONE;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_ONE;

    unique case (state_q)
      S_IDLE: begin
        if (edge_w) begin
          state_d = S_SYNC;
          good_d  = 4'd0;
        end
      end
      S_SYNC: begin
        if (edge_w) begin
          if (good_w) begin
            good_d = gnext;
            if (gnext >= 4'(LOCK_N))
              state_d = S_LOCKED;
          end else begin
            good_d = 4'd0;
          end
        end else if (tout_w) begin
          state_d = S_IDLE;
          good_d  = 4'd0;
        end
      end
      S_LOCKED: begin
        if ((edge_w && !good_w) || tout_w) begin
          state_d = S_FAULT;
          fault_w = 1'b1;
        end
      end
      S_FAULT: begin
        if (edge_w) begin
          state_d = S_SYNC;
          good_d  = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The first edge after idle only starts timing; nothing is reported
    ep_d  = edge_w && (state_q != S_IDLE);
    hp_d  = ep_d ? cnt_q : hp_q;
    lk_d  = (state_d == S_LOCKED);
    err_d = fault_w;
    stk_d = fault_w | (stk_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      led_q   <= 1'b0;
      cnt_q   <= '0;
      good_q  <= 4'd0;
      hp_q    <= '0;
      ep_q    <= 1'b0;
      lk_q    <= 1'b0;
      err_q   <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      hp_q    <= hp_d;
      ep_q    <= ep_d;
      lk_q    <= lk_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
    end
  end

  assign edge_pulse  = ep_q;
  assign half_period = hp_q;
  assign locked      = lk_q;
  assign err_pulse   = err_q;
  assign err_sticky  = stk_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_blink_monitor;

  localparam int CBITS  = 4;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;
  localparam int EXP    = 16;
  localparam int SAT    = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             led_in;
  logic             clr_err;
  logic             edge_pulse;
  logic [CBITS:0]   half_period;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;

  int checks = 0;
  int errors = 0;
  int nerr   = 0;

  blink_monitor #(
    .CBITS (CBITS),
    .TOL   (TOL),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .clr_err    (clr_err),
    .edge_pulse (edge_pulse),
    .half_period(half_period),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: modes 0 idle, 1 sync, 2 locked, 3 fault
  int m_mode, m_run, m_t, m_last, m_prev;
  int m_hp, m_ep, m_err, m_stk;

  task automatic mdl_reset();
    m_mode = 0; m_run = 0; m_t = 0; m_last = 0;
    m_prev = 0; m_hp = 0; m_ep = 0; m_err = 0;
    m_stk = 0;
  endtask

  task automatic mdl_step(int led, int clr);
    int  iv;
    bit  e, ok, to;
    iv = m_t - m_last;
    if (iv > SAT) iv = SAT;
    e  = (led != m_prev);
    ok = (iv >= EXP - TOL) && (iv <= EXP + TOL);
    to = !e && (iv == EXP + TOL);
    m_ep = 0;
    m_err = 0;
    if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_run = 0; end
    end else if (m_mode == 1) begin
      if (e) begin
        m_ep = 1; m_hp = iv;
        if (ok) begin
          m_run++;
          if (m_run >= LOCK_N) m_mode = 2;
        end else m_run = 0;
      end else if (to) begin
        m_mode = 0; m_run = 0;
      end
    end else if (m_mode == 2) begin
      if (e) begin m_ep = 1; m_hp = iv; end
      if ((e && !ok) || to) begin
        m_mode = 3; m_err = 1;
      end
    end else begin
      if (e) begin
        m_ep = 1; m_hp = iv; m_mode = 1; m_run = 0;
      end
    end
    if (m_err != 0) m_stk = 1;
    else if (clr != 0) m_stk = 0;
    if (e) m_last = m_t;
    m_t++;
    m_prev = led;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mdl_reset();
    else mdl_step(int'(led_in), int'(clr_err));
    #1;
    chk("m_edge_pulse", int'(edge_pulse), m_ep);
    chk("m_half_period", int'(half_period), m_hp);
    chk("m_locked", int'(locked), int'(m_mode == 2));
    chk("m_err_pulse", int'(err_pulse), m_err);
    chk("m_err_sticky", int'(err_sticky), m_stk);
    if (err_pulse) nerr++;
  end

  task automatic gap(int n);
    repeat (n) @(negedge clk);
    led_in = ~led_in;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  int n0;
  int gl[5] = '{14, 18, 13, 16, 16};
  int gk[4] = '{14, 18, 16, 16};

  initial begin
    rst = 1'b0;
    led_in = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_locked", int'(locked), 0);
    chk("rst_hp", int'(half_period), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_ep", int'(edge_pulse), 0);
    rst = 1'b1;

    // steady 16-cycle blink locks on the fifth toggle
    gap(3);
    for (int i = 0; i < 4; i++) begin
      gap(16);
      after_edge();
      chk("lock_hp16", int'(half_period), 16);
      chk("lock_ep", int'(edge_pulse), 1);
      chk("lock_state", int'(locked), int'(i == 3));
    end
    chk("lock_sticky0", int'(err_sticky), 0);

    // missing edge while locked -> timeout fault
    n0 = nerr;
    repeat (20) @(negedge clk);
    chk("to_pulses", nerr - n0, 1);
    chk("to_locked", int'(locked), 0);
    chk("to_sticky", int'(err_sticky), 1);
    gap(1);
    after_edge();
    chk("fault_ep", int'(edge_pulse), 1);
    for (int i = 0; i < 4; i++) gap(16);
    after_edge();
    chk("relock1", int'(locked), 1);

    // clear alone
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    after_edge();
    chk("clr_sticky", int'(err_sticky), 0);

    // short interval with coincident clear: set wins
    repeat (7) @(negedge clk);
    @(negedge clk);
    led_in = ~led_in;
    clr_err = 1'b1;
    after_edge();
    chk("short_hp10", int'(half_period), 10);
    chk("short_err", int'(err_pulse), 1);
    chk("short_sticky", int'(err_sticky), 1);
    chk("short_locked", int'(locked), 0);
    @(negedge clk);
    clr_err = 1'b0;
    gap(15);

    // boundary intervals: 13 breaks the run
    for (int i = 0; i < 5; i++) gap(gl[i]);
    after_edge();
    chk("bnd13_nolock", int'(locked), 0);
    chk("bnd_hp16", int'(half_period), 16);
    gap(19);
    after_edge();
    chk("bnd19_noep", int'(edge_pulse), 0);
    for (int i = 0; i < 4; i++) begin
      gap(gk[i]);
      after_edge();
      chk("bnd_lock", int'(locked), int'(i == 3));
    end

    // async reset mid-interval while locked
    n0 = nerr;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    led_in = 1'b1;
    #2;
    chk("arst_locked", int'(locked), 0);
    chk("arst_sticky", int'(err_sticky), 0);
    chk("arst_hp", int'(half_period), 0);
    chk("arst_err", int'(err_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) gap(16);
    after_edge();
    chk("arst_relock", int'(locked), 1);
    chk("arst_nopulse", nerr - n0, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
